shift_zero_solution_gen: RTL and testbench
==========================================

// Module: shift_zero_solution_gen
// PURPOSE
//   Stimulus-side counterpart of the shift-zero constraint checkers. The checker
//   asserts when (v << SHIFT), truncated to WIDTH bits, equals zero.
//   This block produces values that satisfy that constraint, one at a time, and
//   hands them out over a valid/ready handshake. It uses LFSR rejection sampling
//   with a bounded retry budget; when the budget runs out it builds a solution directly.
//   It sits upstream of the constraint checker and feeds it solver stimulus.
// PARAMETERS
//   WIDTH     10  width of the generated variable (sol_value)
//   SHIFT     2   left-shift amount of the constraint; pass = v[WIDTH-SHIFT-1:0]==0
//   MAX_TRIES 16  random candidates tried before the forced fallback (1..255)
// PORTS
//   clk        in   1      clock, rising edge
//   rst        in   1      asynchronous reset, active-high
//   seed_load  in   1      load seed into the LFSR this cycle
//   seed       in   16     LFSR seed; 16'h0000 is replaced by 16'h0001
//   gen_req    in   1      request a solution; sampled only in IDLE
//   busy       out  1      high in SEARCH
//   sol_valid  out  1      solution available (HOLD state)
//   sol_ready  in   1      consumer accepts the solution
//   sol_value  out  WIDTH  solution; always satisfies the constraint
//   sol_forced out  1      1 = built by the fallback, 0 = random hit
//   sol_tries  out  8      number of candidates examined for this solution (1..MAX_TRIES)
// BEHAVIOUR
//   - Reset:
//     - state=IDLE; lfsr=16'h0001.
//     - busy, sol_valid and sol_forced are 0; sol_value=0; sol_tries=0.
//   - LFSR: 16-bit Galois, right shift.
//     - Update: lfsr <= (lfsr>>1) ^ (lfsr[0] ? 16'hB400 : 0).
//     - It advances once per SEARCH cycle and holds in all other states.
//     - candidate = lfsr[WIDTH-1:0].
//     - If SHIFT >= WIDTH, every candidate passes.
//   - FSM IDLE -> SEARCH -> HOLD -> IDLE:
//     - IDLE: gen_req=1 moves to SEARCH next cycle and clears the try counter.
//     - SEARCH: each cycle tests the current candidate and increments tries.
//       - Pass: latch sol_value=candidate, sol_forced=0, then go to HOLD.
//       - Fail on try MAX_TRIES: latch the candidate with bits [WIDTH-SHIFT-1:0]
//         zeroed, sol_forced=1, then go to HOLD.
//     - HOLD: sol_valid=1. sol_value, sol_forced and sol_tries stay stable until
//       sol_valid&&sol_ready.
//       - On handshake with gen_req=1: go to SEARCH; sol_valid drops for at least one cycle.
//       - On handshake with gen_req=0: go to IDLE.
//   - Latency:
//     - Best case, sol_valid rises 2 cycles after gen_req is sampled in IDLE.
//     - Worst case is MAX_TRIES+1 cycles.
//   - seed_load has priority over the LFSR update in any state.
//     - In SEARCH it also resets tries to 0; the search continues from the new seed.
//     - In HOLD the held output is not disturbed.
//   - sol_ready outside HOLD is ignored. gen_req outside IDLE and HOLD-handshake is ignored.
//   - Reset mid-SEARCH or mid-HOLD: return to the reset values immediately; the
//     held solution is discarded.
// CONFIGURATION
//   SOLGEN_STATS_EN defined: adds two ports.
//     - stat_sol_cnt [15:0] out: number of accepted handshakes.
//     - stat_forced_cnt [15:0] out: number of accepted handshakes with sol_forced=1.
//     - Both counters saturate at 16'hFFFF and are cleared by rst.
//   SOLGEN_STATS_EN undefined: those ports and counters do not exist; all other
//   behaviour is identical.
// TESTING (WIDTH=10, SHIFT=2 unless noted)
//   1. seed_load with seed=16'h0100, then gen_req=1, sol_ready=1
//      -> sol_value=10'h100, sol_forced=0, sol_tries=1, valid 2 cycles after request.
//   2. seed=16'h0001, then gen_req
//      -> first candidate 10'h001 fails; LFSR becomes 16'hB400; sol_value=10'h000, sol_tries=2.
//   3. MAX_TRIES=1, seed=16'h0303
//      -> sol_value=10'h300, sol_forced=1, sol_tries=1.
//   4. Hold sol_ready=0 for 5 cycles in HOLD -> sol_valid and sol_value stay stable;
//      the handshake completes on the first cycle with ready=1.
//   5. Assert rst during SEARCH -> all outputs return to reset values in the same cycle;
//      the next request restarts from lfsr=16'h0001.
//   6. With SOLGEN_STATS_EN: 3 accepted solutions, one of them forced
//      -> stat_sol_cnt=3, stat_forced_cnt=1.
//      Across all tests, every sol_value fed to the constraint checker must yield 1.

Source files
------------

// File: rtl/shift_zero_solution_gen.sv
// rtl/shift_zero_solution_gen.sv - LFSR rejection-sampling generator of values v with (v << SHIFT) truncated to WIDTH == 0
// Optional statistics counters are enabled by defining SOLGEN_STATS_EN.
module shift_zero_solution_gen #(
    parameter int WIDTH     = 10,
    parameter int SHIFT     = 2,
    parameter int MAX_TRIES = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    input  logic             gen_req,
    output logic             busy,
    output logic             sol_valid,
    input  logic             sol_ready,
    output logic [WIDTH-1:0] sol_value,
    output logic             sol_forced,
    output logic [7:0]       sol_tries
`ifdef SOLGEN_STATS_EN
    ,
    output logic [15:0]      stat_sol_cnt,
    output logic [15:0]      stat_forced_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        HOLD   = 2'd2
    } state_t;

    // Bits that must be zero for the shifted value to vanish; empty when SHIFT >= WIDTH.
    localparam int              LOW_BITS = (SHIFT >= WIDTH) ? 0 : (WIDTH - SHIFT);
    localparam logic [WIDTH-1:0] LOW_MASK = ~({WIDTH{1'b1}} << LOW_BITS);
    localparam logic [7:0]      MAX_T    = 8'(MAX_TRIES);
    localparam logic [15:0]     LFSR_TAPS = 16'hB400;

    state_t           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [7:0]       tries_q, tries_d;
    logic             busy_q, busy_d;
    logic             sol_valid_q, sol_valid_d;
    logic [WIDTH-1:0] sol_value_q, sol_value_d;
    logic             sol_forced_q, sol_forced_d;
    logic [7:0]       sol_tries_q, sol_tries_d;

    logic [15:0]      lfsr_next;
    logic [WIDTH-1:0] cand;
    logic             cand_pass;
    logic [7:0]       tries_inc;
    logic             handshake;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = lfsr_q;
        tries_d      = tries_q;
        sol_value_d  = sol_value_q;
        sol_forced_d = sol_forced_q;
        sol_tries_d  = sol_tries_q;

        lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        cand      = lfsr_q[WIDTH-1:0];
        cand_pass = ((cand & LOW_MASK) == '0);
        tries_inc = tries_q + 8'd1;
        handshake = (state_q == HOLD) && sol_ready;

        case (state_q)
            IDLE: begin
                if (gen_req) begin
                    state_d = SEARCH;
                    tries_d = 8'd0;
                end
            end
            SEARCH: begin
                if (seed_load) begin
                    // Restart the budget; the new seed's first candidate is tested next cycle.
                    tries_d = 8'd0;
                end else begin
                    lfsr_d  = lfsr_next;
                    tries_d = tries_inc;
                    if (cand_pass) begin
                        sol_value_d  = cand;
                        sol_forced_d = 1'b0;
                        sol_tries_d  = tries_inc;
                        state_d      = HOLD;
                    end else if (tries_inc >= MAX_T) begin
                        sol_value_d  = cand & ~LOW_MASK;
                        sol_forced_d = 1'b1;
                        sol_tries_d  = tries_inc;
                        state_d      = HOLD;
                    end
                end
            end
            HOLD: begin
                if (handshake) begin
                    if (gen_req) begin
                        state_d = SEARCH;
                        tries_d = 8'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (seed_load) begin
            lfsr_d = (seed == 16'h0000) ? 16'h0001 : seed;
        end

        busy_d      = (state_d == SEARCH);
        sol_valid_d = (state_d == HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            lfsr_q       <= 16'h0001;
            tries_q      <= 8'd0;
            busy_q       <= 1'b0;
            sol_valid_q  <= 1'b0;
            sol_value_q  <= '0;
            sol_forced_q <= 1'b0;
            sol_tries_q  <= 8'd0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            tries_q      <= tries_d;
            busy_q       <= busy_d;
            sol_valid_q  <= sol_valid_d;
            sol_value_q  <= sol_value_d;
            sol_forced_q <= sol_forced_d;
            sol_tries_q  <= sol_tries_d;
        end
    end

    assign busy       = busy_q;
    assign sol_valid  = sol_valid_q;
    assign sol_value  = sol_value_q;
    assign sol_forced = sol_forced_q;
    assign sol_tries  = sol_tries_q;

`ifdef SOLGEN_STATS_EN
    logic [15:0] sol_cnt_q, sol_cnt_d;
    logic [15:0] forced_cnt_q, forced_cnt_d;

    always_comb begin
        sol_cnt_d    = sol_cnt_q;
        forced_cnt_d = forced_cnt_q;
        if (handshake && (sol_cnt_q != 16'hFFFF)) begin
            sol_cnt_d = sol_cnt_q + 16'd1;
        end
        if (handshake && sol_forced_q && (forced_cnt_q != 16'hFFFF)) begin
            forced_cnt_d = forced_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sol_cnt_q    <= 16'd0;
            forced_cnt_q <= 16'd0;
        end else begin
            sol_cnt_q    <= sol_cnt_d;
            forced_cnt_q <= forced_cnt_d;
        end
    end

    assign stat_sol_cnt    = sol_cnt_q;
    assign stat_forced_cnt = forced_cnt_q;
`endif

endmodule

// File: tb/tb_shift_zero_solution_gen.sv
// tb/tb_shift_zero_solution_gen.sv - randomized self-checking bench for shift_zero_solution_gen
module tb_shift_zero_solution_gen;

    localparam int W  = 10;
    localparam int S  = 2;
    localparam int MT = 16;
    localparam int BOUND = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          seed_load = 1'b0;
    logic [15:0]   seed = 16'h0;
    logic          gen_req = 1'b0;
    logic          sol_ready = 1'b0;
    logic          busy, sol_valid, sol_forced;
    logic [W-1:0]  sol_value;
    logic [7:0]    sol_tries;

    logic          b_seed_load = 1'b0;
    logic [15:0]   b_seed = 16'h0;
    logic          b_gen_req = 1'b0;
    logic          b_sol_ready = 1'b0;
    logic          b_busy, b_sol_valid, b_sol_forced;
    logic [W-1:0]  b_sol_value;
    logic [7:0]    b_sol_tries;

`ifdef SOLGEN_STATS_EN
    logic [15:0] stat_sol_cnt, stat_forced_cnt, b_stat_sol_cnt, b_stat_forced_cnt;
`endif

    shift_zero_solution_gen #(.WIDTH(W), .SHIFT(S), .MAX_TRIES(MT)) dut (
        .clk(clk), .rst(rst), .seed_load(seed_load), .seed(seed), .gen_req(gen_req),
        .busy(busy), .sol_valid(sol_valid), .sol_ready(sol_ready), .sol_value(sol_value),
        .sol_forced(sol_forced), .sol_tries(sol_tries)
`ifdef SOLGEN_STATS_EN
        , .stat_sol_cnt(stat_sol_cnt), .stat_forced_cnt(stat_forced_cnt)
`endif
    );

    shift_zero_solution_gen #(.WIDTH(W), .SHIFT(S), .MAX_TRIES(1)) dut1 (
        .clk(clk), .rst(rst), .seed_load(b_seed_load), .seed(b_seed), .gen_req(b_gen_req),
        .busy(b_busy), .sol_valid(b_sol_valid), .sol_ready(b_sol_ready), .sol_value(b_sol_value),
        .sol_forced(b_sol_forced), .sol_tries(b_sol_tries)
`ifdef SOLGEN_STATS_EN
        , .stat_sol_cnt(b_stat_sol_cnt), .stat_forced_cnt(b_stat_forced_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;
    logic [15:0] m_lfsr = 16'h0001;
    logic [15:0] b_lfsr = 16'h0001;
    int m_sol = 0, m_forced = 0, b_sol = 0, b_forced = 0;
    int last_v, last_t;
    bit last_f;

    // Reference: walk the LFSR sequence as plain integers until a value whose low W-S bits are zero.
    function automatic void model_search(input logic [15:0] lf_in, input int max_tries,
                                         output logic [15:0] lf_out, output int value,
                                         output bit forced, output int tries);
        int lf;
        int cand;
        lf = int'(lf_in);
        value = 0;
        forced = 1'b0;
        tries = 0;
        for (int k = 1; k <= max_tries; k++) begin
            cand = lf % (1 << W);
            tries = k;
            lf = (lf % 2 == 1) ? ((lf / 2) ^ 'hB400) : (lf / 2);
            if (cand % (1 << (W - S)) == 0) begin
                value = cand;
                break;
            end
            if (k == max_tries) begin
                value = cand - cand % (1 << (W - S));
                forced = 1'b1;
            end
        end
        lf_out = lf[15:0];
    endfunction

    task automatic load_seed(input logic [15:0] s);
        @(negedge clk);
        seed_load = 1'b1;
        seed = s;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr = (s == 16'h0) ? 16'h0001 : s;
    endtask

    // Entered at the negedge just after the edge that sampled the request.
    task automatic wait_result(input string tag);
        int n;
        logic [15:0] lf;
        n = 1;
        while (sol_valid !== 1'b1 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        sol_ready = 1'b0;
        model_search(m_lfsr, MT, lf, last_v, last_f, last_t);
        m_lfsr = lf;
        checks++;
        if (sol_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s timeout: sol_valid=%b after %0d cycles, want 1", tag, sol_valid, n);
        end
        checks++;
        if (n != last_t + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d want %0d", tag, n, last_t + 1);
        end
        checks++;
        if (sol_value !== W'(last_v)) begin
            errors++;
            $display("FAIL %s sol_value: got %h want %h", tag, sol_value, W'(last_v));
        end
        checks++;
        if (sol_forced !== last_f) begin
            errors++;
            $display("FAIL %s sol_forced: got %b want %b", tag, sol_forced, last_f);
        end
        checks++;
        if (sol_tries !== 8'(last_t)) begin
            errors++;
            $display("FAIL %s sol_tries: got %0d want %0d", tag, sol_tries, last_t);
        end
        checks++;
        if (busy !== 1'b0 || (int'(sol_value) % (1 << (W - S))) != 0) begin
            errors++;
            $display("FAIL %s busy/constraint: busy=%b value=%h want busy=0 and low bits zero", tag, busy, sol_value);
        end
    endtask

    task automatic request(input string tag);
        @(negedge clk);
        gen_req = 1'b1;
        sol_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        gen_req = 1'b0;
        wait_result(tag);
    endtask

    task automatic accept(input string tag, input int stall);
        logic [W-1:0] v;
        logic f;
        logic [7:0] t;
        v = sol_value;
        f = sol_forced;
        t = sol_tries;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (sol_valid !== 1'b1 || sol_value !== v || sol_forced !== f || sol_tries !== t) begin
                errors++;
                $display("FAIL %s hold stability: valid=%b value=%h forced=%b tries=%0d want 1 %h %b %0d",
                         tag, sol_valid, sol_value, sol_forced, sol_tries, v, f, t);
            end
        end
        sol_ready = 1'b1;
        gen_req = 1'b0;
        @(negedge clk);
        sol_ready = 1'b0;
        m_sol++;
        m_forced += int'(f);
        checks++;
        if (sol_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: valid=%b busy=%b want 0 0", tag, sol_valid, busy);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || sol_valid !== 1'b0 || sol_forced !== 1'b0 ||
            sol_value !== '0 || sol_tries !== 8'd0) begin
            errors++;
            $display("FAIL reset outputs: busy=%b valid=%b forced=%b value=%h tries=%0d want all 0",
                     busy, sol_valid, sol_forced, sol_value, sol_tries);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed;
        load_seed(16'h0100);
        request("seed0100");
        checks++;
        if (sol_value !== 10'h100 || sol_tries !== 8'd1 || sol_forced !== 1'b0) begin
            errors++;
            $display("FAIL seed0100 const: value=%h tries=%0d forced=%b want 100 1 0", sol_value, sol_tries, sol_forced);
        end
        accept("seed0100", 0);
        load_seed(16'h0001);
        request("seed0001");
        checks++;
        if (sol_value !== 10'h000 || sol_tries !== 8'd2) begin
            errors++;
            $display("FAIL seed0001 const: value=%h tries=%0d want 000 2", sol_value, sol_tries);
        end
        accept("seed0001_stall5", 5);
        load_seed(16'h0000);
        request("seed0000");
        accept("seed0000", 1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) load_seed(16'($urandom));
            request("random");
            accept("random", $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back;
        load_seed(16'($urandom));
        request("b2b_first");
        for (int i = 0; i < 6; i++) begin
            sol_ready = 1'b1;
            gen_req = 1'b1;
            @(negedge clk);
            sol_ready = 1'b0;
            gen_req = 1'b0;
            m_sol++;
            m_forced += int'(last_f);
            checks++;
            if (sol_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL b2b gap: valid=%b busy=%b want 0 1", sol_valid, busy);
            end
            wait_result("b2b");
        end
        accept("b2b_last", 0);
    endtask

    task automatic test_hold_seed;
        logic [W-1:0] v;
        logic [15:0] s;
        load_seed(16'($urandom));
        request("hold_seed");
        v = sol_value;
        s = 16'($urandom);
        seed_load = 1'b1;
        seed = s;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr = (s == 16'h0) ? 16'h0001 : s;
        checks++;
        if (sol_valid !== 1'b1 || sol_value !== v) begin
            errors++;
            $display("FAIL hold_seed stability: valid=%b value=%h want 1 %h", sol_valid, sol_value, v);
        end
        accept("hold_seed", 1);
        request("after_hold_seed");
        accept("after_hold_seed", 0);
    endtask

    task automatic test_reset_mid_search;
        load_seed(16'h0001);
        @(negedge clk);
        gen_req = 1'b1;
        @(posedge clk);
        #1;
        gen_req = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid busy before reset: got %b want 1", busy);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || sol_valid !== 1'b0 || sol_forced !== 1'b0 ||
            sol_value !== '0 || sol_tries !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid outputs: busy=%b valid=%b forced=%b value=%h tries=%0d want all 0",
                     busy, sol_valid, sol_forced, sol_value, sol_tries);
        end
        @(negedge clk);
        rst = 1'b0;
        m_lfsr = 16'h0001;
        b_lfsr = 16'h0001;
        m_sol = 0;
        m_forced = 0;
        b_sol = 0;
        b_forced = 0;
        request("after_rst");
        checks++;
        if (sol_value !== 10'h000 || sol_tries !== 8'd2) begin
            errors++;
            $display("FAIL after_rst const: value=%h tries=%0d want 000 2", sol_value, sol_tries);
        end
        accept("after_rst", 0);
    endtask

    task automatic test_max_tries_one;
        logic [15:0] s, lf;
        int v, t, n;
        bit f;
        for (int i = 0; i < 8; i++) begin
            s = (i == 0) ? 16'h0303 : 16'($urandom);
            @(negedge clk);
            b_seed_load = 1'b1;
            b_seed = s;
            @(negedge clk);
            b_seed_load = 1'b0;
            b_lfsr = (s == 16'h0) ? 16'h0001 : s;
            b_gen_req = 1'b1;
            @(negedge clk);
            b_gen_req = 1'b0;
            n = 1;
            while (b_sol_valid !== 1'b1 && n < BOUND) begin
                @(negedge clk);
                n++;
            end
            model_search(b_lfsr, 1, lf, v, f, t);
            b_lfsr = lf;
            checks++;
            if (b_sol_valid !== 1'b1 || n != 2 || b_sol_value !== W'(v) || b_sol_forced !== f || b_sol_tries !== 8'(t)) begin
                errors++;
                $display("FAIL max1 seed %h: valid=%b lat=%0d value=%h forced=%b tries=%0d want 1 2 %h %b %0d",
                         s, b_sol_valid, n, b_sol_value, b_sol_forced, b_sol_tries, W'(v), f, t);
            end
            if (i == 0) begin
                checks++;
                if (b_sol_value !== 10'h300 || b_sol_forced !== 1'b1) begin
                    errors++;
                    $display("FAIL max1 const: value=%h forced=%b want 300 1", b_sol_value, b_sol_forced);
                end
            end
            b_sol_ready = 1'b1;
            @(negedge clk);
            b_sol_ready = 1'b0;
            b_sol++;
            b_forced += int'(f);
        end
    endtask

    task automatic test_stats;
`ifdef SOLGEN_STATS_EN
        checks++;
        if (stat_sol_cnt !== 16'(m_sol) || stat_forced_cnt !== 16'(m_forced)) begin
            errors++;
            $display("FAIL stats main: sol=%0d forced=%0d want %0d %0d", stat_sol_cnt, stat_forced_cnt, m_sol, m_forced);
        end
        checks++;
        if (b_stat_sol_cnt !== 16'(b_sol) || b_stat_forced_cnt !== 16'(b_forced)) begin
            errors++;
            $display("FAIL stats max1: sol=%0d forced=%0d want %0d %0d", b_stat_sol_cnt, b_stat_forced_cnt, b_sol, b_forced);
        end
`endif
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_hold_seed;
        test_reset_mid_search;
        test_random;
        test_max_tries_one;
        test_stats;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
